// File: rtl/gauss_pkg.sv
// Shared constants and types for the 3x3 Gaussian column-stream core.
package gauss_pkg;

  localparam int unsigned DEFAULT_PIXEL_W    = 8;
  localparam int unsigned DEFAULT_LINE_WIDTH = 512;
  localparam int unsigned VSUM_W             = 10;
  localparam int unsigned HSUM_W             = 12;
  localparam int unsigned NORM_SHIFT         = 4;

  // Position class of the incoming column, used for left-border replication.
  typedef enum logic [1:0] {
    COL_FIRST  = 2'd0,
    COL_SECOND = 2'd1,
    COL_BODY   = 2'd2
  } col_phase_e;

endpackage

// File: rtl/gauss_vsum.sv
// Combinational 1-2-1 vertical sum of one pixel column.
module gauss_vsum
  import gauss_pkg::*;
#(
  parameter int unsigned PIXEL_W = DEFAULT_PIXEL_W,
  parameter int unsigned SUM_W   = PIXEL_W + (VSUM_W - DEFAULT_PIXEL_W)
) (
  input  logic [PIXEL_W-1:0] pix_top_i,
  input  logic [PIXEL_W-1:0] pix_mid_i,
  input  logic [PIXEL_W-1:0] pix_bot_i,
  output logic [SUM_W-1:0]   vsum_c_o
);

  assign vsum_c_o = SUM_W'(pix_top_i) + SUM_W'({pix_mid_i, 1'b0}) + SUM_W'(pix_bot_i);

endmodule

// File: rtl/gauss3x3_col_stream.sv
// Streaming 3x3 Gaussian smoother: one column in, one filtered pixel out,
// two register stages (window + horizontal sum, then output) under valid/ack.
module gauss3x3_col_stream
  import gauss_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int unsigned PIXEL_W    = DEFAULT_PIXEL_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIXEL_W-1:0] i_pixel_1,
  input  logic [PIXEL_W-1:0] i_pixel_2,
  input  logic [PIXEL_W-1:0] i_pixel_3,
  input  logic               i_pixel_valid,
  output logic               o_pixel_ack,
  output logic               o_pixel_valid,
  input  logic               i_pixel_ack,
  output logic [PIXEL_W-1:0] o_pixel
);

  localparam int unsigned VS_W  = PIXEL_W + (VSUM_W - DEFAULT_PIXEL_W);
  localparam int unsigned HS_W  = PIXEL_W + (HSUM_W - DEFAULT_PIXEL_W);
  localparam int unsigned COL_W = (LINE_WIDTH > 2) ? $clog2(LINE_WIDTH) : 2;

  logic              adv_c;
  logic              in_xfer_c;
  logic [VS_W-1:0]   vsum_c;
  logic [VS_W-1:0]   win_l_c;
  logic [VS_W-1:0]   win_m_c;
  logic [HS_W-1:0]   hsum_c;
  col_phase_e        phase_c;

  logic [COL_W-1:0]   col_q,       col_d;
  logic [VS_W-1:0]    prev1_q,     prev1_d;
  logic [VS_W-1:0]    prev2_q,     prev2_d;
  logic [HS_W-1:0]    s1_hsum_q,   s1_hsum_d;
  logic               s1_valid_q,  s1_valid_d;
  logic [PIXEL_W-1:0] out_pix_q,   out_pix_d;
  logic               out_valid_q, out_valid_d;

  gauss_vsum #(
    .PIXEL_W (PIXEL_W),
    .SUM_W   (VS_W)
  ) u_vsum (
    .pix_top_i (i_pixel_1),
    .pix_mid_i (i_pixel_2),
    .pix_bot_i (i_pixel_3),
    .vsum_c_o  (vsum_c)
  );

  // Whole pipeline moves together whenever the output slot is free or being taken.
  assign adv_c     = i_pixel_ack || !out_valid_q;
  assign in_xfer_c = i_pixel_valid && adv_c;

  // Left-border replication: the first two columns of a line reuse v(0).
  always_comb begin
    phase_c = COL_BODY;
    if (col_q == COL_W'(0)) begin
      phase_c = COL_FIRST;
    end else if (col_q == COL_W'(1)) begin
      phase_c = COL_SECOND;
    end
  end

  always_comb begin
    win_l_c = prev2_q;
    win_m_c = prev1_q;
    unique case (phase_c)
      COL_FIRST: begin
        win_l_c = vsum_c;
        win_m_c = vsum_c;
      end
      COL_SECOND: begin
        win_l_c = prev1_q;
        win_m_c = prev1_q;
      end
      default: begin
        win_l_c = prev2_q;
        win_m_c = prev1_q;
      end
    endcase
    hsum_c = HS_W'(win_l_c) + HS_W'({win_m_c, 1'b0}) + HS_W'(vsum_c);
  end

  always_comb begin
    col_d       = col_q;
    prev1_d     = prev1_q;
    prev2_d     = prev2_q;
    s1_hsum_d   = s1_hsum_q;
    s1_valid_d  = s1_valid_q;
    out_pix_d   = out_pix_q;
    out_valid_d = out_valid_q;
    if (adv_c) begin
      out_pix_d   = PIXEL_W'(s1_hsum_q >> NORM_SHIFT);
      out_valid_d = s1_valid_q;
      s1_valid_d  = in_xfer_c;
      if (in_xfer_c) begin
        s1_hsum_d = hsum_c;
        prev2_d   = win_m_c;
        prev1_d   = vsum_c;
        col_d     = (col_q == COL_W'(LINE_WIDTH - 1)) ? COL_W'(0) : col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q       <= '0;
      prev1_q     <= '0;
      prev2_q     <= '0;
      s1_hsum_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_pix_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      prev1_q     <= prev1_d;
      prev2_q     <= prev2_d;
      s1_hsum_q   <= s1_hsum_d;
      s1_valid_q  <= s1_valid_d;
      out_pix_q   <= out_pix_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_pixel_ack   = adv_c;
  assign o_pixel_valid = out_valid_q;
  assign o_pixel       = out_pix_q;

endmodule

// File: tb/tb_gauss3x3_col_stream.sv
// Scoreboard bench for gauss3x3_col_stream: driver pushes reference results,
// a negedge monitor pops and compares whenever an output transfer occurs.
module tb_gauss3x3_col_stream;

  localparam int LW = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p1 = '0, p2 = '0, p3 = '0;
  logic       in_valid = 1'b0;
  logic       in_ack;
  logic       out_valid;
  logic       out_ack = 1'b1;
  logic [7:0] out_pix;

  gauss3x3_col_stream #(.LINE_WIDTH(LW), .PIXEL_W(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pixel_1     (p1),
    .i_pixel_2     (p2),
    .i_pixel_3     (p3),
    .i_pixel_valid (in_valid),
    .o_pixel_ack   (in_ack),
    .o_pixel_valid (out_valid),
    .i_pixel_ack   (out_ack),
    .o_pixel       (out_pix)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp;
    int cexp;
    int acc;
    bit lat;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-line vertical sums, border replication on cols 0/1.
  int line_v[LW];
  int m_col = 0;

  task automatic model_col(input int a, input int b, input int c, output int e);
    int v, vl, vm;
    v = a + 2 * b + c;
    line_v[m_col] = v;
    vl = (m_col >= 2) ? line_v[m_col - 2] : line_v[0];
    vm = (m_col >= 1) ? line_v[m_col - 1] : line_v[0];
    e = (vl + 2 * vm + v) / 16;
    m_col = (m_col == LW - 1) ? 0 : m_col + 1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: handshake rule, hold stability, and scoreboard pop on transfer.
  bit   hold_pend = 1'b0;
  int   hold_pix  = 0;
  sb_t  e_mon;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      check("ack_rule", int'(in_ack), int'(out_ack || !out_valid));
      if (hold_pend) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_pixel", int'(out_pix), hold_pix);
      end
      hold_pend = out_valid && !out_ack;
      hold_pix  = int'(out_pix);
      if (out_valid && out_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check("pixel_model", int'(out_pix), e_mon.exp);
          if (e_mon.cexp >= 0) check("pixel_const", int'(out_pix), e_mon.cexp);
          if (e_mon.lat) check("latency", cyc, e_mon.acc + 1);
        end
      end
    end
  end

  bit rand_mode = 1'b0;
  int ack_low   = 0;

  task automatic set_ack();
    if (ack_low > 0) begin
      out_ack = 1'b0;
      ack_low--;
    end else if (rand_mode) begin
      out_ack = ($urandom_range(0, 3) != 0);
    end else begin
      out_ack = 1'b1;
    end
  endtask

  // Offers one column until accepted; called at posedge+1.
  task automatic send_col(input int a, input int b, input int c, input int cexp, input bit lat);
    bit  done = 1'b0;
    int  guard = 0;
    int  e;
    sb_t ent;
    while (!done) begin
      set_ack();
      if (rand_mode && $urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        p1 = 8'(a);
        p2 = 8'(b);
        p3 = 8'(c);
      end
      @(negedge clk);
      if (in_valid && in_ack) begin
        model_col(a, b, c, e);
        ent.exp  = e;
        ent.cexp = cexp;
        ent.acc  = cyc + 1;
        ent.lat  = lat;
        sb.push_back(ent);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 200) begin
        check("accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    rand_mode = 1'b0;
    ack_low   = 0;
    in_valid  = 1'b0;
    out_ack   = 1'b1;
    while ((sb.size() != 0 || out_valid) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  int v, ce;

  initial begin
    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_pixel", int'(out_pix), 0);
    check("rst_ack", int'(in_ack), 1);
    @(posedge clk);
    #1;

    // Line 1: flat field, latency checked
    for (int c = 0; c < LW; c++) send_col(100, 100, 100, 100, 1'b1);

    // Line 2: border columns, random body, all-255 last column
    send_col(16, 16, 16, 16, 1'b0);
    send_col(32, 32, 32, 20, 1'b0);
    rand_mode = 1'b1;
    for (int c = 2; c < LW - 1; c++)
      send_col(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), -1, 1'b0);
    send_col(255, 255, 255, -1, 1'b0);

    // Line 3: impulse; column 0 also proves no leakage across the wrap
    for (int c = 0; c < LW; c++) begin
      v  = (c == 5) ? 160 : 0;
      ce = (c == 5 || c == 7) ? 20 : (c == 6) ? 40 : 0;
      send_col(0, v, 0, ce, 1'b0);
    end

    // Line 4: ramp with a 5-cycle downstream stall
    rand_mode = 1'b0;
    for (int c = 0; c < LW; c++) begin
      if (c == 100) ack_low = 5;
      send_col(c % 256, c % 256, c % 256, -1, 1'b0);
    end

    // Line 5: saturation bound
    rand_mode = 1'b1;
    for (int c = 0; c < LW; c++) send_col(255, 255, 255, 255, 1'b0);

    // Partial line then reset mid-stream
    for (int c = 0; c < 200; c++)
      send_col(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), -1, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    m_col = 0;
    @(negedge clk);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_pixel", int'(out_pix), 0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++)
      send_col(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), -1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
